// File: rtl/sdram_rr_arbiter_if.sv
// Requester-side and controller-side Avalon-MM signals of the SDRAM arbiter.
// req_lock exists only when SDRAM_ARB_LOCK_EN is defined.
interface sdram_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int AW    = 25,
    parameter int DW    = 16
);
    logic [N_REQ*AW-1:0]   req_address;
    logic [N_REQ-1:0]      req_read;
    logic [N_REQ-1:0]      req_write;
    logic [N_REQ*DW-1:0]   req_writedata;
    logic [N_REQ*DW/8-1:0] req_byteenable;
    logic [N_REQ-1:0]      req_waitrequest;
    logic [DW-1:0]         req_readdata;
    logic [N_REQ-1:0]      req_readdatavalid;
`ifdef SDRAM_ARB_LOCK_EN
    logic [N_REQ-1:0]      req_lock;
`endif
    logic [AW-1:0]         m_address;
    logic                  m_read;
    logic                  m_write;
    logic [DW-1:0]         m_writedata;
    logic [DW/8-1:0]       m_byteenable;
    logic                  m_waitrequest;
    logic [DW-1:0]         m_readdata;
    logic                  m_readdatavalid;

    modport slave (
`ifdef SDRAM_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_address, req_read, req_write,
        input  req_writedata, req_byteenable,
        output req_waitrequest, req_readdata, req_readdatavalid,
        output m_address, m_read, m_write,
        output m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    modport master (
`ifdef SDRAM_ARB_LOCK_EN
        output req_lock,
`endif
        output req_address, req_read, req_write,
        output req_writedata, req_byteenable,
        input  req_waitrequest, req_readdata, req_readdatavalid,
        input  m_address, m_read, m_write,
        input  m_writedata, m_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/sdram_rr_arbiter.sv
// Round-robin Avalon-MM arbiter in front of one SDRAM controller, with read-ID FIFO.
// Optional locked bursts when SDRAM_ARB_LOCK_EN is defined.
module sdram_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int AW       = 25,
    parameter int DW       = 16,
    parameter int MAX_PEND = 4
`ifdef SDRAM_ARB_LOCK_EN
    ,
    parameter int LOCK_MAX = 4
`endif
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    sdram_rr_arbiter_if.slave      bus,
    output logic                   err_orphan
);
    localparam int GW = $clog2(N_REQ);
    localparam int PW = $clog2(MAX_PEND);
    localparam int BW = DW / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_nxt;
    logic [GW-1:0]  gnt, gnt_nxt;
    logic [GW-1:0]  ptr, ptr_nxt;
    logic [GW-1:0]  fifo [MAX_PEND];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [PW:0]    count;
    logic           full, empty;
    logic           push, pop;
    logic           cmd_rd, cmd_wr, accept;
    logic [N_REQ-1:0] pending;
`ifdef SDRAM_ARB_LOCK_EN
    localparam int LW = $clog2(LOCK_MAX + 1);
    logic [LW-1:0]  lock_cnt, lock_nxt;
`endif

    assign full  = (count == (PW+1)'(MAX_PEND));
    assign empty = (count == '0);

    // Read wins over write on the same requester; a read is held off while the FIFO is full.
    assign cmd_rd = (state == BUSY) && bus.req_read[gnt] && !full;
    assign cmd_wr = (state == BUSY) && bus.req_write[gnt] && !bus.req_read[gnt];
    assign accept = (cmd_rd || cmd_wr) && !bus.m_waitrequest;
    assign push   = accept && cmd_rd;
    assign pop    = bus.m_readdatavalid && !empty;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pending[i] = bus.req_read[i] ? !full : bus.req_write[i];
        end
    end

    always_comb begin
        bus.m_address       = '0;
        bus.m_writedata     = '0;
        bus.m_byteenable    = '0;
        bus.m_read          = cmd_rd;
        bus.m_write         = cmd_wr;
        bus.req_waitrequest = '1;
        bus.req_readdatavalid = '0;
        bus.req_readdata    = bus.m_readdata;
        if (state == BUSY) begin
            bus.m_address    = bus.req_address[int'(gnt)*AW +: AW];
            bus.m_writedata  = bus.req_writedata[int'(gnt)*DW +: DW];
            bus.m_byteenable = bus.req_byteenable[int'(gnt)*BW +: BW];
        end
        if (accept) begin
            bus.req_waitrequest[gnt] = 1'b0;
        end
        if (pop) begin
            bus.req_readdatavalid[fifo[rd_ptr]] = 1'b1;
        end
    end

    always_comb begin
        logic found;
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        found     = 1'b0;
`ifdef SDRAM_ARB_LOCK_EN
        lock_nxt  = lock_cnt;
`endif
        unique case (state)
            IDLE: begin
`ifdef SDRAM_ARB_LOCK_EN
                lock_nxt = '0;
`endif
                for (int k = 1; k <= N_REQ; k++) begin
                    int idx;
                    idx = (int'(ptr) + k) % N_REQ;
                    if (!found && pending[idx]) begin
                        gnt_nxt = GW'(idx);
                        found   = 1'b1;
                    end
                end
                if (found) state_nxt = BUSY;
            end
            BUSY: begin
                // Nothing issuable on the owner: release the bus.
                if (!(cmd_rd || cmd_wr)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt;
`ifdef SDRAM_ARB_LOCK_EN
                    lock_nxt  = '0;
`endif
                end else if (accept) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt;
`ifdef SDRAM_ARB_LOCK_EN
                    lock_nxt  = '0;
                    if (bus.req_lock[gnt] && lock_cnt < LW'(LOCK_MAX - 1)) begin
                        state_nxt = BUSY;
                        lock_nxt  = lock_cnt + LW'(1);
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            gnt        <= '0;
            ptr        <= GW'(N_REQ - 1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
`ifdef SDRAM_ARB_LOCK_EN
            lock_cnt   <= '0;
`endif
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
`ifdef SDRAM_ARB_LOCK_EN
            lock_cnt <= lock_nxt;
`endif
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (bus.m_readdatavalid && empty) err_orphan <= 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) fifo[wr_ptr] <= gnt;
    end
endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed bench for sdram_rr_arbiter.
// Lock scenario runs only when SDRAM_ARB_LOCK_EN is defined.
module tb_sdram_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 25;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_orphan;
    int   total = 0;
    int   bad = 0;

    sdram_rr_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus();

    sdram_rr_arbiter #(
        .N_REQ(N), .AW(AW), .DW(DW), .MAX_PEND(4)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .bus          (bus),
        .err_orphan   (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_inputs;
        bus.req_address     = '0;
        bus.req_read        = '0;
        bus.req_write       = '0;
        bus.req_writedata   = '0;
        bus.req_byteenable  = '0;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdata      = '0;
        bus.m_readdatavalid = 1'b0;
`ifdef SDRAM_ARB_LOCK_EN
        bus.req_lock        = '0;
`endif
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        clear_inputs();
        #12;
        chk("rst_wait", bus.req_waitrequest, 4'hF);
        chk("rst_rdv", bus.req_readdatavalid, 4'h0);
        chk("rst_mread", bus.m_read, 1'b0);
        chk("rst_mwrite", bus.m_write, 1'b0);
        chk("rst_maddr", bus.m_address, '0);
        chk("rst_err", err_orphan, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: single write
        bus.req_write[0] = 1'b1;
        bus.req_address[0*AW +: AW] = 25'h100;
        bus.req_writedata[0*DW +: DW] = 16'hBEEF;
        bus.req_byteenable[1:0] = 2'b11;
        settle();
        chk("t1_lat_mwrite", bus.m_write, 1'b0);
        tick();
        chk("t1_mwrite", bus.m_write, 1'b1);
        chk("t1_maddr", bus.m_address, 32'h100);
        chk("t1_mwdata", bus.m_writedata, 32'hBEEF);
        chk("t1_mbe", bus.m_byteenable, 2'b11);
        chk("t1_wait", bus.req_waitrequest, 4'hE);
        tick();
        chk("t1_wait_after", bus.req_waitrequest, 4'hF);
        bus.req_write = '0;
        settle();
        chk("t1_mwrite_after", bus.m_write, 1'b0);

        // 2: four simultaneous reads, round-robin from reset pointer
        do_reset();
        for (int i = 0; i < N; i++) bus.req_address[i*AW +: AW] = 25'(32'h200 + i);
        bus.req_read = 4'hF;
        for (int i = 0; i < N; i++) begin
            tick();
            e = 4'hF ^ (4'b0001 << i);
            chk("t2_mread", bus.m_read, 1'b1);
            chk("t2_maddr", bus.m_address, 32'h200 + i);
            chk("t2_wait", bus.req_waitrequest, e);
            tick();
            bus.req_read[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata = 16'(32'hA000 + i);
            settle();
            chk("t2_rdv", bus.req_readdatavalid, 4'b0001 << i);
            chk("t2_rdata", bus.req_readdata, 32'hA000 + i);
            tick();
        end
        bus.m_readdatavalid = 1'b0;

        // 3: FIFO full blocks reads but not writes
        bus.req_address[0*AW +: AW] = 25'h400;
        bus.req_read[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_issue", bus.m_read, 1'b1);
            tick();
        end
        bus.req_address[1*AW +: AW] = 25'h300;
        bus.req_write[1] = 1'b1;
        tick();
        chk("t3_wr_mwrite", bus.m_write, 1'b1);
        chk("t3_wr_mread", bus.m_read, 1'b0);
        chk("t3_wr_maddr", bus.m_address, 32'h300);
        chk("t3_wr_wait", bus.req_waitrequest, 4'hD);
        tick();
        bus.req_write[1] = 1'b0;
        tick();
        chk("t3_blocked", bus.m_read, 1'b0);
        chk("t3_blocked_wait", bus.req_waitrequest, 4'hF);
        tick();
        chk("t3_blocked2", bus.m_read, 1'b0);
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata = 16'h00C0;
        settle();
        chk("t3_pop_rdv", bus.req_readdatavalid, 4'h1);
        tick();
        bus.m_readdatavalid = 1'b0;
        settle();
        chk("t3_arb_cycle", bus.m_read, 1'b0);
        tick();
        chk("t3_fifth", bus.m_read, 1'b1);
        chk("t3_fifth_wait", bus.req_waitrequest, 4'hE);
        tick();
        bus.req_read[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.m_readdatavalid = 1'b1;
            settle();
            chk("t3_drain", bus.req_readdatavalid, 4'h1);
            tick();
        end
        bus.m_readdatavalid = 1'b0;

        // 4: controller stall holds the command
        bus.m_waitrequest = 1'b1;
        bus.req_address[2*AW +: AW] = 25'h40;
        bus.req_read[2] = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("t4_stall_mread", bus.m_read, 1'b1);
            chk("t4_stall_maddr", bus.m_address, 32'h40);
            chk("t4_stall_wait", bus.req_waitrequest, 4'hF);
            tick();
        end
        bus.m_waitrequest = 1'b0;
        settle();
        chk("t4_acc_wait", bus.req_waitrequest, 4'hB);
        chk("t4_acc_mread", bus.m_read, 1'b1);
        chk("t4_acc_maddr", bus.m_address, 32'h40);
        tick();
        bus.req_read[2] = 1'b0;
        settle();
        chk("t4_done_wait", bus.req_waitrequest, 4'hF);
        chk("t4_done_mread", bus.m_read, 1'b0);

        // 5: reset mid-BUSY with two reads outstanding
        bus.req_address[3*AW +: AW] = 25'h50;
        bus.req_read[3] = 1'b1;
        tick();
        chk("t5_rd3_maddr", bus.m_address, 32'h50);
        tick();
        bus.req_read[3] = 1'b0;
        bus.req_address[1*AW +: AW] = 25'h60;
        bus.req_read[1] = 1'b1;
        bus.m_waitrequest = 1'b1;
        tick();
        chk("t5_busy_mread", bus.m_read, 1'b1);
        chk("t5_busy_maddr", bus.m_address, 32'h60);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mread", bus.m_read, 1'b0);
        chk("t5_rst_maddr", bus.m_address, '0);
        chk("t5_rst_wait", bus.req_waitrequest, 4'hF);
        bus.req_read = '0;
        bus.m_waitrequest = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_err_clear", err_orphan, 1'b0);
        bus.m_readdatavalid = 1'b1;
        settle();
        chk("t5_orphan_rdv", bus.req_readdatavalid, 4'h0);
        tick();
        bus.m_readdatavalid = 1'b0;
        settle();
        chk("t5_err_set", err_orphan, 1'b1);
        tick();
        chk("t5_err_sticky", err_orphan, 1'b1);

`ifdef SDRAM_ARB_LOCK_EN
        // 6: locked burst capped at four transfers
        do_reset();
        bus.req_lock = 4'b0010;
        bus.req_address[1*AW +: AW] = 25'h70;
        bus.req_address[2*AW +: AW] = 25'h80;
        bus.req_write = 4'b0110;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t6_lock_wait", bus.req_waitrequest, 4'hD);
            chk("t6_lock_maddr", bus.m_address, 32'h70);
            tick();
        end
        chk("t6_cap_idle", bus.m_write, 1'b0);
        tick();
        chk("t6_req2_wait", bus.req_waitrequest, 4'hB);
        chk("t6_req2_maddr", bus.m_address, 32'h80);
        tick();
        bus.req_write[2] = 1'b0;
        tick();
        chk("t6_resume_wait", bus.req_waitrequest, 4'hD);
        tick();
        chk("t6_resume2_wait", bus.req_waitrequest, 4'hD);
        tick();
        bus.req_write[1] = 1'b0;
        settle();
        chk("t6_release", bus.m_write, 1'b0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
